// File: rtl/img_pkg.sv
// Shared types and constants for the image frame controller.
package img_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_WAIT_V = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [1:0] OP_BRIGHT = 2'd0;
  localparam logic [1:0] OP_INV    = 2'd1;
  localparam logic [1:0] OP_THRESH = 2'd2;
  localparam logic [1:0] OP_PASS   = 2'd3;

  localparam int DEF_WIDTH  = 768;
  localparam int DEF_HEIGHT = 512;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/img_wdog.sv
// Idle-cycle watchdog: expires after WDOG_CYC enabled cycles with no kick.
module img_wdog
  import img_pkg::*;
#(
  parameter int WDOG_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_kick,
  output logic o_expire
);

  localparam int CW = cnt_w(WDOG_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(WDOG_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_cnt <= '0;
    else if (!i_en || i_kick) r_cnt <= '0;
    else if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
  end

  // The current cycle is the WDOG_CYC-th consecutive quiet one.
  assign o_expire = i_en && !i_kick && (r_cnt == CNT_LAST);

endmodule

// File: rtl/img_frame_ctrl.sv
// Frame sequencer for the image reader; optional sync watchdog enabled by
// defining IMG_FRAME_WDOG_EN.
module img_frame_ctrl
  import img_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int RST_PULSE = 4,
  parameter int WDOG_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_req,
  input  logic [1:0]  op_sel,
  input  logic [7:0]  op_value,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        rd_done_in,
  output logic        rdr_rst_n,
  output logic        frame_ack,
  output logic [1:0]  op_sel_q,
  output logic [7:0]  op_value_q,
  output logic        busy,
  output logic [9:0]  line_cnt,
  output logic [8:0]  pair_cnt,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam int RCW = cnt_w(RST_PULSE);
  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_PULSE - 1);
  localparam logic [8:0]     PAIR_LAST = 9'(WIDTH / 2 - 1);
  localparam logic [9:0]     LINE_LAST = 10'(HEIGHT - 1);

  state_t         r_state;
  logic [RCW-1:0] r_rst_cnt;
  logic           r_vs_seen;
  logic           w_last;
  logic           w_pair_end;
  logic           w_expire;

  assign w_pair_end = (pair_cnt == PAIR_LAST);
  assign w_last     = w_pair_end && (line_cnt == LINE_LAST);
  assign busy       = (r_state != S_IDLE);

`ifdef IMG_FRAME_WDOG_EN
  logic r_vs_d;
  logic r_hs_d;
  logic w_wd_en;
  logic w_kick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d <= 1'b0;
      r_hs_d <= 1'b0;
    end else begin
      r_vs_d <= vsync_in;
      r_hs_d <= hsync_in;
    end
  end

  assign w_wd_en = (r_state == S_WAIT_V) || (r_state == S_STREAM);
  assign w_kick  = (vsync_in != r_vs_d) || (hsync_in != r_hs_d);

  img_wdog #(.WDOG_CYC(WDOG_CYC)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_wd_en),
    .i_kick   (w_kick),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rst_cnt  <= '0;
      r_vs_seen  <= 1'b0;
      rdr_rst_n  <= 1'b0;
      frame_ack  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      op_sel_q   <= OP_PASS;
      op_value_q <= 8'd0;
      line_cnt   <= 10'd0;
      pair_cnt   <= 9'd0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_ack  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          rdr_rst_n <= 1'b1;
          if (frame_req) begin
            r_state    <= S_RST;
            frame_ack  <= 1'b1;
            op_sel_q   <= op_sel;
            op_value_q <= op_value;
            rdr_rst_n  <= 1'b0;
            line_cnt   <= 10'd0;
            pair_cnt   <= 9'd0;
            r_rst_cnt  <= '0;
            r_vs_seen  <= 1'b0;
          end
        end
        S_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            r_state   <= S_WAIT_V;
            rdr_rst_n <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_WAIT_V: begin
          if (w_expire) begin
            r_state   <= S_ERR;
            frame_err <= 1'b1;
            rdr_rst_n <= 1'b0;
          end else if (vsync_in) begin
            r_vs_seen <= 1'b1;
          end else if (r_vs_seen) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          // rd_done is only legal together with the final pair's hsync.
          if (rd_done_in) begin
            if (hsync_in && w_last) begin
              r_state    <= S_DONE;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end else begin
              r_state   <= S_ERR;
              frame_err <= 1'b1;
              rdr_rst_n <= 1'b0;
            end
          end else if (w_expire || (hsync_in && w_last)) begin
            r_state   <= S_ERR;
            frame_err <= 1'b1;
            rdr_rst_n <= 1'b0;
          end else if (hsync_in) begin
            if (w_pair_end) begin
              pair_cnt <= 9'd0;
              line_cnt <= line_cnt + 10'd1;
            end else begin
              pair_cnt <= pair_cnt + 9'd1;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_ERR: begin
          r_state   <= S_IDLE;
          rdr_rst_n <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_frame_ctrl.sv
// Directed bench for img_frame_ctrl (WIDTH=8, HEIGHT=4, RST_PULSE=4, WDOG_CYC=32).
module tb_img_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_req = 1'b0;
  logic [1:0]  op_sel = 2'd0;
  logic [7:0]  op_value = 8'd0;
  logic        vsync_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        rd_done_in = 1'b0;
  logic        rdr_rst_n;
  logic        frame_ack;
  logic [1:0]  op_sel_q;
  logic [7:0]  op_value_q;
  logic        busy;
  logic [9:0]  line_cnt;
  logic [8:0]  pair_cnt;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int n_ack = 0, n_done = 0, n_err = 0, n_rlow = 0;
  int b_ack, b_done, b_err, b_rlow;

  img_frame_ctrl #(.WIDTH(8), .HEIGHT(4), .RST_PULSE(4), .WDOG_CYC(32)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .op_sel(op_sel),
    .op_value(op_value), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .rd_done_in(rd_done_in), .rdr_rst_n(rdr_rst_n), .frame_ack(frame_ack),
    .op_sel_q(op_sel_q), .op_value_q(op_value_q), .busy(busy),
    .line_cnt(line_cnt), .pair_cnt(pair_cnt), .frame_done(frame_done),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_ack === 1'b1)  n_ack++;
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1)  n_err++;
    if (rdr_rst_n === 1'b0 && busy === 1'b1) n_rlow++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_ack = n_ack; b_done = n_done; b_err = n_err; b_rlow = n_rlow;
  endtask

  task automatic start_frame(input logic [1:0] s, input logic [7:0] v, input logic hold);
    @(negedge clk);
    op_sel = s; op_value = v; frame_req = 1'b1;
    @(negedge clk);
    chk("ack_pulse", frame_ack, 1);
    if (!hold) frame_req = 1'b0;
  endtask

  task automatic sync_v();
    int n = 0;
    while (rdr_rst_n !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rdr_release_in_budget", (n < 20), 1);
    vsync_in = 1'b1;
    @(negedge clk);
    vsync_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic h, input logic d);
    @(negedge clk);
    hsync_in = h; rd_done_in = d;
    @(negedge clk);
    hsync_in = 1'b0; rd_done_in = 1'b0;
  endtask

  task automatic run_frame();
    for (int i = 0; i < 16; i++) drive(1'b1, (i == 15));
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rdr_rst_n", rdr_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {frame_ack, frame_done, frame_err}, 0);
    chk("rst_counters", {line_cnt, pair_cnt, frame_cnt}, 0);
    chk("rst_op_sel_q", op_sel_q, 3);
    chk("rst_op_value_q", op_value_q, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdr_rst_n", rdr_rst_n, 1);

    // Nominal frame, with a stray request while busy
    snap();
    start_frame(2'd2, 8'd90, 1'b0);
    chk("nom_busy", busy, 1);
    chk("nom_op_sel_q", op_sel_q, 2);
    chk("nom_op_value_q", op_value_q, 90);
    chk("nom_rdr_low", rdr_rst_n, 0);
    sync_v();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    chk("nom_mid_pos", {22'd0, line_cnt}, 1);
    chk("nom_mid_pair", {23'd0, pair_cnt}, 1);
    @(negedge clk); frame_req = 1'b1; op_sel = 2'd0;
    @(negedge clk); frame_req = 1'b0;
    for (int i = 5; i < 16; i++) drive(1'b1, (i == 15));
    chk("nom_done_pulse", frame_done, 1);
    chk("nom_frame_cnt", frame_cnt, 1);
    @(negedge clk);
    chk("nom_idle", busy, 0);
    chk("nom_done_level", frame_done, 0);
    chk("nom_ack_count", n_ack - b_ack, 1);
    chk("nom_done_count", n_done - b_done, 1);
    chk("nom_err_count", n_err - b_err, 0);
    chk("nom_rdr_low_cycles", n_rlow - b_rlow, 4);
    chk("nom_op_sel_hold", op_sel_q, 2);

    // Early rd_done at line 2, pair 1
    snap();
    start_frame(2'd1, 8'd5, 1'b0);
    sync_v();
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0);
    chk("early_pos", {line_cnt, pair_cnt}, {10'd2, 9'd1});
    drive(1'b0, 1'b1);
    chk("early_err_pulse", frame_err, 1);
    chk("early_err_rdr_low", rdr_rst_n, 0);
    @(negedge clk);
    chk("early_idle", busy, 0);
    chk("early_rdr_high", rdr_rst_n, 1);
    chk("early_frame_cnt", frame_cnt, 1);
    chk("early_done_count", n_done - b_done, 0);
    chk("early_err_count", n_err - b_err, 1);

    // Overrun: keep pulsing hsync without rd_done
    snap();
    start_frame(2'd3, 8'd0, 1'b0);
    sync_v();
    begin
      int k = 0;
      while (frame_err !== 1'b1 && k < 17) begin
        drive(1'b1, 1'b0);
        k++;
      end
    end
    @(negedge clk);
    chk("ovr_err_count", n_err - b_err, 1);
    chk("ovr_done_count", n_done - b_done, 0);
    chk("ovr_idle", busy, 0);
    chk("ovr_frame_cnt", frame_cnt, 1);

    // Watchdog: stall mid-line
    snap();
    start_frame(2'd0, 8'd7, 1'b0);
    sync_v();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
`ifdef IMG_FRAME_WDOG_EN
    repeat (40) @(negedge clk);
    chk("wdog_err_count", n_err - b_err, 1);
    chk("wdog_idle", busy, 0);
    start_frame(2'd0, 8'd7, 1'b0);
    sync_v();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
`else
    repeat (100) @(negedge clk);
    chk("nowdog_busy", busy, 1);
    chk("nowdog_pos", {line_cnt, pair_cnt}, {10'd0, 9'd2});
    chk("nowdog_err_count", n_err - b_err, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
`endif

    // Asynchronous reset mid-frame at line 1
    chk("mid_pos", {line_cnt, pair_cnt}, {10'd1, 9'd1});
    snap();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_rdr", rdr_rst_n, 0);
    chk("async_counters", {line_cnt, pair_cnt, frame_cnt}, 0);
    chk("async_op", {op_sel_q, op_value_q}, {2'd3, 8'd0});
    repeat (3) @(negedge clk);
    chk("async_no_pulses", (n_done - b_done) + (n_err - b_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("async_release_rdr", rdr_rst_n, 1);

    // Back-to-back with frame_req held high
    snap();
    start_frame(2'd1, 8'd10, 1'b1);
    chk("b2b_val1", op_value_q, 10);
    op_value = 8'd20;
    sync_v();
    chk("b2b_val_stable", op_value_q, 10);
    run_frame();
    chk("b2b_done1", frame_done, 1);
    chk("b2b_cnt1", frame_cnt, 1);
    @(negedge clk);
    chk("b2b_gap_idle", busy, 0);
    @(negedge clk);
    chk("b2b_ack2", frame_ack, 1);
    chk("b2b_val2", op_value_q, 20);
    frame_req = 1'b0;
    sync_v();
    run_frame();
    @(negedge clk);
    chk("b2b_cnt2", frame_cnt, 2);
    chk("b2b_idle", busy, 0);
    chk("b2b_ack_count", n_ack - b_ack, 2);
    chk("b2b_done_count", n_done - b_done, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
